// File: rtl/kgd_blitter.sv
// kgd_blitter: Wishbone master that fills or copies bytes of the KGD video buffer through its
// non-incrementing address/data register pair. Optional macro KGD_BLIT_AUTOSHOW_EN adds a final ctrl write.
module kgd_blitter #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 14
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_start,
  input  logic          cmd_abort,
  input  logic          cmd_mode,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW:0]   cmd_len,
  input  logic [7:0]    cmd_fill,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    m_adr_o,
  output logic [15:0]   m_dat_o,
  input  logic [15:0]   m_dat_i,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  output logic          m_we_o,
  output logic [1:0]    m_sel_o,
  input  logic          m_ack_i
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] ONE_W   = {{(WDW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]  ONE_A   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]    ONE_C   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F_ADR  = 4'd1,
    F_DAT  = 4'd2,
    C_SADR = 4'd3,
    C_RD   = 4'd4,
    C_DADR = 4'd5,
    C_WR   = 4'd6,
    NEXT   = 4'd7,
    SHOW   = 4'd8,
    FIN    = 4'd9
  } state_e;

`ifdef KGD_BLIT_AUTOSHOW_EN
  localparam state_e LAST_ST = SHOW;
`else
  localparam state_e LAST_ST = FIN;
`endif

  state_e          state_q;
  logic            mode_q;
  logic [AW-1:0]   src_q;
  logic [AW-1:0]   dst_q;
  logic [AW:0]     cnt_q;
  logic [7:0]      fill_q;
  logic [7:0]      byte_q;
  logic [WDW-1:0]  wdog_q;
  logic            abort_q;
  logic            first_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [1:0]      sel_q;
  logic [2:0]      adr_q;
  logic [15:0]     dat_q;

  logic [2:0]      bus_adr_d;
  logic [15:0]     bus_dat_d;
  logic            bus_we_d;
  logic [1:0]      bus_sel_d;
  state_e          bus_nxt_d;
  logic            abort_now_s;
  logic            dat_hi_unused_s;

  assign abort_now_s     = abort_q | cmd_abort;
  assign dat_hi_unused_s = ^m_dat_i[15:8];

  // Bus-cycle contents for the current state and the state reached after its ack.
  always_comb begin
    bus_adr_d = 3'd0;
    bus_dat_d = 16'h0000;
    bus_we_d  = 1'b1;
    bus_sel_d = 2'b11;
    bus_nxt_d = FIN;
    case (state_q)
      F_ADR:   begin bus_adr_d = 3'd4; bus_dat_d = 16'(dst_q);        bus_nxt_d = F_DAT;  end
      F_DAT:   begin bus_adr_d = 3'd2; bus_dat_d = {8'h00, fill_q};   bus_sel_d = 2'b01; bus_nxt_d = NEXT; end
      C_SADR:  begin bus_adr_d = 3'd4; bus_dat_d = 16'(src_q);        bus_nxt_d = C_RD;   end
      C_RD:    begin bus_adr_d = 3'd2; bus_we_d  = 1'b0;              bus_nxt_d = C_DADR; end
      C_DADR:  begin bus_adr_d = 3'd4; bus_dat_d = 16'(dst_q);        bus_nxt_d = C_WR;   end
      C_WR:    begin bus_adr_d = 3'd2; bus_dat_d = {8'h00, byte_q};   bus_sel_d = 2'b01; bus_nxt_d = NEXT; end
      SHOW:    begin bus_adr_d = 3'd0; bus_dat_d = 16'hC000;          bus_sel_d = 2'b10; bus_nxt_d = FIN;  end
      default: begin bus_nxt_d = FIN; end
    endcase
  end

  // Sequencer: each bus state first launches its cycle from idle, then waits for ack or watchdog.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 8'h00;
      byte_q  <= 8'h00;
      wdog_q  <= '0;
      abort_q <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      adr_q   <= 3'd0;
      dat_q   <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            mode_q  <= cmd_mode;
            src_q   <= cmd_src;
            dst_q   <= cmd_dst;
            cnt_q   <= cmd_len;
            fill_q  <= cmd_fill;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            abort_q <= cmd_abort;
            first_q <= 1'b1;
            if (cmd_len == '0)  state_q <= FIN;
            else if (cmd_mode)  state_q <= C_SADR;
            else                state_q <= F_ADR;
          end
        end
        F_ADR, F_DAT, C_SADR, C_RD, C_DADR, C_WR, SHOW: begin
          if (cmd_abort) abort_q <= 1'b1;
          // A start-time abort must let the first bus cycle run before it takes effect.
          if (!cyc_q) begin
            if (abort_now_s && !first_q) begin
              state_q <= FIN;
            end else begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              adr_q   <= bus_adr_d;
              dat_q   <= bus_dat_d;
              we_q    <= bus_we_d;
              sel_q   <= bus_sel_d;
              wdog_q  <= '0;
              first_q <= 1'b0;
            end
          end else if (m_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (state_q == C_RD) byte_q <= m_dat_i[7:0];
            state_q <= abort_now_s ? FIN : bus_nxt_d;
          end else if (wdog_q == WD_LAST) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            wdog_q <= wdog_q + ONE_W;
          end
        end
        NEXT: begin
          src_q <= src_q + ONE_A;
          dst_q <= dst_q + ONE_A;
          cnt_q <= cnt_q - ONE_C;
          if (cmd_abort) abort_q <= 1'b1;
          if (abort_now_s)         state_q <= FIN;
          else if (cnt_q == ONE_C) state_q <= LAST_ST;
          else if (mode_q)         state_q <= C_SADR;
          else                     state_q <= F_ADR;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = stb_q;
  assign m_we_o  = we_q;
  assign m_sel_o = sel_q;

endmodule

// File: tb/tb_kgd_blitter.sv
// Bench for kgd_blitter: a KGD register-slave model with a byte memory, and an expected bus-cycle
// queue built from the command rules, compared against the master every cycle a cycle is open.
module tb_kgd_blitter;
  localparam int AW      = 14;
  localparam int TIMEOUT = 64;
  localparam int MEMSZ   = 1 << AW;
`ifdef KGD_BLIT_AUTOSHOW_EN
  localparam int SHOW_N = 1;
`else
  localparam int SHOW_N = 0;
`endif

  logic          wb_clk_i;
  logic          wb_rst_i;
  logic          cmd_start, cmd_abort, cmd_mode;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [AW:0]   cmd_len;
  logic [7:0]    cmd_fill;
  logic          busy, done, err;
  logic [2:0]    m_adr_o;
  logic [15:0]   m_dat_o, m_dat_i;
  logic          m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic [1:0]    m_sel_o;

  kgd_blitter #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .busy(busy), .done(done), .err(err),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [2:0]  adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dat;
  } tx_t;

  tx_t           exp_q[$];
  tx_t           log_q[$];
  logic [7:0]    mem     [MEMSZ];
  logic [7:0]    exp_mem [MEMSZ];
  logic [AW-1:0] areg;
  int checks, passed;
  int lat, lat_lo, lat_hi, wcnt, stb_cycles, done_cnt, tx_cnt;
  bit noack;

  // Read cycles carry no meaningful write data, so their data field is ignored.
  function automatic tx_t mk(input logic [2:0] a, input logic w, input logic [1:0] s, input logic [15:0] d);
    mk = {a, w, s, (w ? d : 16'h0000)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Slave model and per-cycle bus comparison against the expected-cycle queue.
  always @(negedge wb_clk_i) begin
    tx_t cur;
    if (wb_rst_i) begin
      m_ack_i = 1'b0;
      wcnt    = 0;
    end else begin
      if (done) done_cnt++;
      if (m_ack_i) begin
        chk("cyc_dropped_on_ack", 32'(m_cyc_o), 32'd0);
        m_ack_i = 1'b0;
      end else if (m_cyc_o) begin
        stb_cycles++;
        cur = mk(m_adr_o, m_we_o, m_sel_o, m_dat_o);
        chk("stb_with_cyc", 32'(m_stb_o), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_bus_cycle", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("bus_cycle_fields", 32'(cur), 32'(exp_q[0]));
          wcnt++;
          if (!noack && wcnt >= lat) begin
            if (m_we_o && m_adr_o == 3'd4)      areg = m_dat_o[AW-1:0];
            else if (m_we_o && m_adr_o == 3'd2) mem[areg] = m_dat_o[7:0];
            else if (!m_we_o)                   m_dat_i = {8'($urandom), mem[areg]};
            void'(exp_q.pop_front());
            log_q.push_back(cur);
            tx_cnt++;
            wcnt    = 0;
            lat     = $urandom_range(lat_hi, lat_lo);
            m_ack_i = 1'b1;
          end
        end
      end
    end
  end

  task automatic build_exp(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW:0] len, input logic [7:0] fill, input int mem_len);
    logic [AW-1:0] s, d;
    logic [7:0]    b;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      s = AW'((int'(src) + i) % MEMSZ);
      d = AW'((int'(dst) + i) % MEMSZ);
      if (!mode) begin
        b = fill;
        exp_q.push_back(mk(3'd4, 1'b1, 2'b11, 16'(d)));
        exp_q.push_back(mk(3'd2, 1'b1, 2'b01, {8'h00, b}));
      end else begin
        b = exp_mem[s];
        exp_q.push_back(mk(3'd4, 1'b1, 2'b11, 16'(s)));
        exp_q.push_back(mk(3'd2, 1'b0, 2'b11, 16'h0000));
        exp_q.push_back(mk(3'd4, 1'b1, 2'b11, 16'(d)));
        exp_q.push_back(mk(3'd2, 1'b1, 2'b01, {8'h00, b}));
      end
      if (i < mem_len) exp_mem[d] = b;
    end
    if (SHOW_N != 0 && len != '0) exp_q.push_back(mk(3'd0, 1'b1, 2'b10, 16'hC000));
  endtask

  task automatic run_cmd(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [AW:0] len, input logic [7:0] fill, input int mem_len,
                         input int exp_tx, input int abort_at, input bit poke, input bit exp_err);
    int  want_tx, budget, mism;
    bit  ab_done;
    build_exp(mode, src, dst, len, fill, mem_len);
    want_tx  = (exp_tx < 0) ? exp_q.size() : exp_tx;
    budget   = 400 + 60 * int'(len);
    tx_cnt   = 0; done_cnt = 0; stb_cycles = 0; wcnt = 0; ab_done = 1'b0;
    log_q.delete();
    lat = $urandom_range(lat_hi, lat_lo);
    @(posedge wb_clk_i); #1;
    cmd_mode = mode; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill; cmd_start = 1'b1;
    @(posedge wb_clk_i); #1;
    cmd_start = 1'b0; cmd_src = ~src; cmd_dst = ~dst; cmd_fill = ~fill;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_on_start", 32'(err), 32'd0);
    if (len == '0) begin
      chk("len0_done_not_yet", 32'(done), 32'd0);
      @(posedge wb_clk_i); #1;
      chk("len0_done_next_cycle", 32'(done), 32'd1);
      chk("len0_busy_dropped", 32'(busy), 32'd0);
    end
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      cmd_abort = 1'b0;
      cmd_start = 1'b0;
      if (abort_at >= 0 && !ab_done && tx_cnt == abort_at && m_cyc_o && m_adr_o == 3'd2) begin
        cmd_abort = 1'b1;
        ab_done   = 1'b1;
      end
      if (poke && c == 3 && busy) begin
        cmd_start = 1'b1;
        cmd_mode  = 1'($urandom);
        cmd_len   = (AW+1)'($urandom_range(9, 1));
        cmd_src   = AW'($urandom);
        cmd_dst   = AW'($urandom);
      end
      @(posedge wb_clk_i); #1;
    end
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    repeat (4) begin @(posedge wb_clk_i); #1; end
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
    chk("busy_at_end", 32'(busy), 32'd0);
    chk("err_at_end", 32'(err), 32'(exp_err));
    chk("completed_cycles", 32'(tx_cnt), 32'(want_tx));
    mism = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) mism++;
    chk("memory_image", 32'(mism), 32'd0);
    exp_q.delete();
    noack = 1'b0;
  endtask

  logic [15:0] lit1 [6];

  initial begin
    checks = 0; passed = 0; noack = 1'b0; lat_lo = 1; lat_hi = 3; lat = 1;
    areg = '0; m_ack_i = 1'b0; m_dat_i = 16'h0000;
    cmd_start = 1'b0; cmd_abort = 1'b0; cmd_mode = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = 8'h00;
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset_outputs", 32'({busy, done, err, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}), 32'd0);
    wb_rst_i = 1'b0;

    // Fill of three bytes with a fixed two-cycle ack latency.
    lat_lo = 2; lat_hi = 2;
    run_cmd(1'b0, 14'h0000, 14'h0100, 15'd3, 8'hA5, 3, -1, -1, 1'b0, 1'b0);
    lit1 = '{16'h0100, 16'h00A5, 16'h0101, 16'h00A5, 16'h0102, 16'h00A5};
    chk("fill3_cycle_count", 32'(log_q.size()), 32'(6 + SHOW_N));
    if (log_q.size() >= 6)
      for (int i = 0; i < 6; i++) chk("fill3_write_data", 32'(log_q[i].dat), 32'(lit1[i]));

    // Copy of two bytes with known source contents.
    lat_lo = 1; lat_hi = 3;
    mem[14'h0010] = 8'h11; exp_mem[14'h0010] = 8'h11;
    mem[14'h0011] = 8'h22; exp_mem[14'h0011] = 8'h22;
    run_cmd(1'b1, 14'h0010, 14'h2000, 15'd2, 8'h00, 2, -1, -1, 1'b0, 1'b0);
    chk("copy_dst0", 32'(mem[14'h2000]), 32'h11);
    chk("copy_dst1", 32'(mem[14'h2001]), 32'h22);
    if (log_q.size() >= 4) begin
      chk("copy_order_adr", 32'({log_q[0].adr, log_q[1].adr, log_q[2].adr, log_q[3].adr}), 32'({3'd4, 3'd2, 3'd4, 3'd2}));
      chk("copy_order_we", 32'({log_q[0].we, log_q[1].we, log_q[2].we, log_q[3].we}), 32'({1'b1, 1'b0, 1'b1, 1'b1}));
    end

    // Address wrap at the top of the buffer.
    run_cmd(1'b0, 14'h0000, 14'h3FFF, 15'd2, 8'h5A, 2, -1, -1, 1'b0, 1'b0);
    if (log_q.size() >= 4) begin
      chk("wrap_first_addr", 32'(log_q[0].dat), 32'h3FFF);
      chk("wrap_second_addr", 32'(log_q[2].dat), 32'h0000);
    end

    // Silent slave: watchdog abort, then the next start clears err.
    noack = 1'b1;
    run_cmd(1'b0, 14'h0000, 14'h0200, 15'd3, 8'h77, 0, 0, -1, 1'b0, 1'b1);
    chk("timeout_stb_cycles", 32'(stb_cycles), 32'(TIMEOUT));
    run_cmd(1'b0, 14'h0000, 14'h0210, 15'd1, 8'h66, 1, -1, -1, 1'b0, 1'b0);

    // Abort during the data cycle of the fourth byte of a ten-byte fill.
    run_cmd(1'b0, 14'h0000, 14'h0300, 15'd10, 8'h3C, 4, 8, 7, 1'b0, 1'b0);

    // Zero-length command.
    run_cmd(1'b0, 14'h0000, 14'h0400, 15'd0, 8'h11, 0, -1, -1, 1'b0, 1'b0);
    chk("len0_no_bus_cycle", 32'(stb_cycles), 32'd0);

`ifdef KGD_BLIT_AUTOSHOW_EN
    run_cmd(1'b0, 14'h0000, 14'h0500, 15'd1, 8'h42, 1, -1, -1, 1'b0, 1'b0);
    if (log_q.size() >= 3)
      chk("autoshow_ctrl_write", 32'(log_q[2]), 32'(mk(3'd0, 1'b1, 2'b10, 16'hC000)));
`endif

    // Randomized commands, with a start pulse injected while busy.
    for (int n = 0; n < 12; n++) begin
      logic [AW:0] rl;
      rl = (AW+1)'($urandom_range(12, 0));
      run_cmd(1'($urandom), AW'($urandom), AW'($urandom), rl, 8'($urandom),
              int'(rl), -1, -1, 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of a transfer.
    build_exp(1'b0, 14'h0000, 14'h0600, 15'd10, 8'h99, 0);
    @(posedge wb_clk_i); #1;
    cmd_mode = 1'b0; cmd_dst = 14'h0600; cmd_len = 15'd10; cmd_fill = 8'h99; cmd_start = 1'b1;
    @(posedge wb_clk_i); #1;
    cmd_start = 1'b0;
    repeat (12) @(posedge wb_clk_i);
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({busy, done, err, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}), 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    exp_q.delete();
    // The abandoned transfer left a partial write in the slave memory; adopt it as the new baseline.
    for (int i = 0; i < MEMSZ; i++) exp_mem[i] = mem[i];
    run_cmd(1'b0, 14'h0000, 14'h0700, 15'd2, 8'hC3, 2, -1, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
